// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared widths and loader state encoding
// Purpose: default bus/address widths and the program loader state enum.
// Ports: none (package).
package sap_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_WAIT,
        LD_ADDR,
        LD_DATA,
        LD_DONE
    } ld_state_e;

endpackage

// File: rtl/loader_addr_ctr.sv
// rtl/loader_addr_ctr.sv - write address counter for the program loader
// Purpose: ADDR_W counter with sync clear, load-zero, increment and at_last compare.
// Ports:
//   clk, clear      clock and synchronous active-high reset
//   load_zero       restart the count at address 0
//   inc             advance to the next address
//   last_addr       final address of the current load
//   count           current address
//   at_last         count equals last_addr
module loader_addr_ctr
    import sap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load_zero,
    input  logic              inc,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] count,
    output logic              at_last
);

    logic [ADDR_W-1:0] count_d;
    logic [ADDR_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load_zero) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_last = (count_q == last_addr);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams program bytes into RAM over the shared bus
// Purpose: accepts bytes on a valid/ready handshake and writes each to RAM as
//          an address cycle (MAR load) followed by a data cycle (RAM write),
//          holding the CPU halted while the load is in progress.
// Ports:
//   clk, clear               clock and synchronous active-high reset
//   start, abort, last_addr  load control; last_addr sampled on accepted start
//   byte_valid/byte_data     byte source
//   byte_ready               loader accepts a byte this cycle
//   bus_out, bus_drive       shared bus value and ownership
//   load_addr_reg, ram_write one-cycle MAR load / RAM write strobes
//   cpu_halt, done, cur_addr status
module program_loader
    import sap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    output logic              byte_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              load_addr_reg,
    output logic              ram_write,
    output logic              cpu_halt,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    ld_state_e         state_d, state_q;
    logic [ADDR_W-1:0] last_d, last_q;
    logic [DATA_W-1:0] byte_d, byte_q;
    logic              ctr_zero;
    logic              ctr_inc;
    logic              at_last;

    loader_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk       (clk),
        .clear     (clear),
        .load_zero (ctr_zero),
        .inc       (ctr_inc),
        .last_addr (last_q),
        .count     (cur_addr),
        .at_last   (at_last)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= LD_IDLE;
            last_q  <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        byte_d   = byte_q;
        ctr_zero = 1'b0;
        ctr_inc  = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start && !abort) begin
                    state_d  = LD_WAIT;
                    last_d   = last_addr;
                    ctr_zero = 1'b1;
                end
            end
            LD_WAIT: begin
                if (abort) begin
                    state_d = LD_IDLE;
                end else if (byte_valid) begin
                    byte_d  = byte_data;
                    state_d = LD_ADDR;
                end
            end
            LD_ADDR: begin
                state_d = abort ? LD_IDLE : LD_DATA;
            end
            LD_DATA: begin
                // The write strobe is already out this cycle; abort only stops what follows.
                if (abort) begin
                    state_d = LD_IDLE;
                end else if (at_last) begin
                    state_d = LD_DONE;
                end else begin
                    ctr_inc = 1'b1;
                    state_d = LD_WAIT;
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // Outputs depend only on the registered state, so a clear leaves no partial strobe.
    always_comb begin
        byte_ready    = 1'b0;
        bus_out       = '0;
        bus_drive     = 1'b0;
        load_addr_reg = 1'b0;
        ram_write     = 1'b0;
        cpu_halt      = 1'b1;
        done          = 1'b0;
        case (state_q)
            LD_IDLE: cpu_halt = 1'b0;
            LD_WAIT: byte_ready = 1'b1;
            LD_ADDR: begin
                bus_drive     = 1'b1;
                bus_out       = DATA_W'(cur_addr);
                load_addr_reg = 1'b1;
            end
            LD_DATA: begin
                bus_drive = 1'b1;
                bus_out   = byte_q;
                ram_write = 1'b1;
            end
            LD_DONE: done = 1'b1;
            default: cpu_halt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

    logic       clk = 1'b0;
    logic       clear, start, abort, byte_valid;
    logic [3:0] last_addr;
    logic [7:0] byte_data;
    logic       byte_ready, bus_drive, load_addr_reg, ram_write, cpu_halt, done;
    logic [7:0] bus_out;
    logic [3:0] cur_addr;

    always #5 clk = ~clk;

    program_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk           (clk),
        .clear         (clear),
        .start         (start),
        .abort         (abort),
        .last_addr     (last_addr),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .bus_out       (bus_out),
        .bus_drive     (bus_drive),
        .load_addr_reg (load_addr_reg),
        .ram_write     (ram_write),
        .cpu_halt      (cpu_halt),
        .done          (done),
        .cur_addr      (cur_addr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a load is "active" while bytes are still owed; each accepted byte
    // occupies two bus cycles (phase 1 = address, phase 2 = data).
    bit chk_en = 0;
    bit m_active = 0, m_done = 0;
    int m_phase = 0, m_addr = 0, m_last = 0, m_byte = 0;

    always @(posedge clk) begin
        if (clear) begin
            m_active = 0; m_done = 0; m_phase = 0; m_addr = 0; m_byte = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1; m_last = int'(last_addr); m_addr = 0;
            end
        end else if (abort) begin
            m_active = 0; m_phase = 0;
        end else if (m_phase == 0) begin
            if (byte_valid) begin
                m_byte = int'(byte_data); m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_phase = 0;
            if (m_addr == m_last) begin
                m_active = 0; m_done = 1;
            end else begin
                m_addr = m_addr + 1;
            end
        end
    end

    // Scoreboard of what actually landed in RAM, plus per-cycle comparison.
    logic [7:0] mem [16];
    logic [7:0] mar = 8'h0;
    int nwr = 0, ndone = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", byte_ready, m_active && m_phase == 0);
            chk("load_addr_reg", load_addr_reg, m_phase == 1);
            chk("ram_write", ram_write, m_phase == 2);
            chk("bus_drive", bus_drive, m_phase != 0);
            chk("bus_out", bus_out, m_phase == 1 ? m_addr : (m_phase == 2 ? m_byte : 0));
            chk("done", done, m_done);
            chk("cpu_halt", cpu_halt, m_active || m_done);
            chk("cur_addr", cur_addr, m_addr);
            chk("strobe_excl", load_addr_reg & ram_write, 0);
        end
        if (load_addr_reg) mar = bus_out;
        if (ram_write) begin
            mem[mar[3:0]] = bus_out;
            nwr++;
        end
        if (done) ndone++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_sb();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        nwr = 0;
        ndone = 0;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1; last_addr = l;
        tick();
        start = 0; last_addr = l ^ 4'hA;
    endtask

    // Holds byte_valid high until the byte is taken; returns in the address cycle.
    task automatic send_byte(input logic [7:0] b);
        bit taken = 0;
        byte_valid = 1; byte_data = b;
        for (int i = 0; i < 10 && !taken; i++) begin
            taken = byte_ready;
            tick();
        end
        if (!taken) chk("accept_timeout", 0, 1);
    endtask

    logic [3:0] done_addr;
    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (done) begin
                seen = 1;
                done_addr = cur_addr;
            end else begin
                tick();
            end
        end
        chk("done_seen", seen, 1);
        tick();
    endtask

    initial begin
        clear = 1; start = 0; abort = 0; last_addr = 0; byte_valid = 0; byte_data = 0;
        tick();
        chk_en = 1;
        tick();
        clear = 0;
        chk("reset_halt", cpu_halt, 0);
        chk("reset_addr", cur_addr, 0);
        chk("reset_drive", bus_drive, 0);

        // three bytes, valid held high through ADDR/DATA with the next byte presented
        reset_sb();
        do_start(4'd2);
        send_byte(8'h1E);
        send_byte(8'h2F);
        send_byte(8'hE0);
        byte_valid = 0;
        wait_done();
        chk("l3_mem0", mem[0], 8'h1E);
        chk("l3_mem1", mem[1], 8'h2F);
        chk("l3_mem2", mem[2], 8'hE0);
        chk("l3_writes", nwr, 3);
        chk("l3_dones", ndone, 1);
        chk("l3_halt_off", cpu_halt, 0);

        // start pulse mid-load is ignored
        reset_sb();
        do_start(4'd1);
        send_byte(8'h11);
        start = 1; last_addr = 4'hF;
        tick();
        start = 0;
        send_byte(8'h22);
        byte_valid = 0;
        wait_done();
        chk("mid_writes", nwr, 2);
        chk("mid_mem1", mem[1], 8'h22);
        chk("mid_dones", ndone, 1);

        // full depth
        reset_sb();
        do_start(4'hF);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        byte_valid = 0;
        wait_done();
        chk("full_writes", nwr, 16);
        chk("full_dones", ndone, 1);
        chk("full_last_addr", done_addr, 4'hF);
        for (int i = 0; i < 16; i++) chk("full_mem", mem[i], 8'(i));

        // single byte
        reset_sb();
        do_start(4'd0);
        send_byte(8'hA5);
        byte_valid = 0;
        wait_done();
        chk("one_writes", nwr, 1);
        chk("one_mem0", mem[0], 8'hA5);

        // abort in WAIT after one byte, then restart at address 0
        reset_sb();
        do_start(4'd5);
        send_byte(8'h33);
        byte_valid = 0;
        for (int i = 0; i < 5 && !byte_ready; i++) tick();
        chk("ab_in_wait", byte_ready, 1);
        abort = 1;
        tick();
        abort = 0;
        chk("ab_halt", cpu_halt, 0);
        repeat (4) tick();
        chk("ab_writes", nwr, 1);
        reset_sb();
        do_start(4'd1);
        send_byte(8'h44);
        send_byte(8'h55);
        byte_valid = 0;
        wait_done();
        chk("re_mem0", mem[0], 8'h44);
        chk("re_mem1", mem[1], 8'h55);
        chk("re_writes", nwr, 2);

        // clear during the address cycle
        reset_sb();
        do_start(4'd3);
        send_byte(8'h66);
        byte_valid = 0;
        chk("clr_in_addr", load_addr_reg, 1);
        clear = 1;
        tick();
        clear = 0;
        chk("clr_no_write", ram_write, 0);
        chk("clr_halt", cpu_halt, 0);
        repeat (3) tick();
        chk("clr_writes", nwr, 0);

        // start together with abort stays idle
        start = 1; abort = 1; last_addr = 4'd2;
        tick();
        start = 0; abort = 0;
        chk("sa_halt", cpu_halt, 0);
        chk("sa_ready", byte_ready, 0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the RAM block.
- Accepts a stream of program bytes over a valid/ready handshake and writes them into RAM at consecutive addresses starting at 0.
- For each byte, it drives the shared bus twice: first the address, with a MAR load pulse; then the data, with a RAM write pulse.
- Holds the CPU in halt while loading, so the program can be loaded without the DIP switches.

Parameters:
DATA_W, 8, bus and RAM word width
ADDR_W, 4, MAR width; RAM depth is 2**ADDR_W

Ports:
clk  input  1  system clock; all state changes on rising edge
clear  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
abort  input  1  cancel the load in progress; takes effect next cycle
last_addr  input  ADDR_W  final address to write; sampled on accepted start
byte_valid  input  1  source has a byte on byte_data
byte_data  input  DATA_W  program byte
byte_ready  output  1  loader can accept a byte this cycle
bus_out  output  DATA_W  value driven onto the shared bus; 0 when bus_drive=0
bus_drive  output  1  loader owns the bus this cycle
load_addr_reg  output  1  one-cycle MAR load strobe
ram_write  output  1  one-cycle RAM write strobe
cpu_halt  output  1  high whenever the loader is not IDLE
done  output  1  one-cycle pulse after the final write
cur_addr  output  ADDR_W  address of the next or current write

Behaviour:
- Reset (clear=1 at an edge) overrides everything, including mid-load:
  - state=IDLE; cur_addr=0; latched byte=0.
  - All outputs 0. No partial strobe may be emitted in the reset cycle.
- States:
  - IDLE:
    - Outputs 0.
    - start=1 and abort=0: latch last_addr, cur_addr=0, go to WAIT.
    - start and abort together: stay in IDLE.
  - WAIT:
    - byte_ready=1, cpu_halt=1.
    - Transfer occurs when byte_valid&byte_ready: capture byte_data, go to ADDR.
    - byte_valid without a transfer has no effect.
  - ADDR:
    - bus_drive=1; bus_out = cur_addr zero-extended to DATA_W; load_addr_reg=1.
    - Go to DATA.
  - DATA:
    - bus_drive=1; bus_out = latched byte; ram_write=1.
    - If cur_addr==last_addr, go to DONE. Otherwise cur_addr+1 and go to WAIT.
  - DONE:
    - done=1, cpu_halt=1. Go to IDLE.
- Latency:
  - Byte accepted in cycle N: load_addr_reg in N+1, ram_write in N+2, byte_ready again in N+3.
  - Maximum throughput is one byte per 3 cycles.
- byte_ready is 0 in every state except WAIT. A byte_valid seen in any other state is ignored and not captured.
- Strobes:
  - load_addr_reg and ram_write are never high in the same cycle.
  - Each is high for exactly one cycle per byte.
- Abort:
  - In WAIT, ADDR or DATA: next state is IDLE and no further strobes are issued.
  - An abort seen in the DATA cycle does not cancel that cycle's write, since the strobe is already issued.
  - In DONE, abort is ignored.
- Boundaries:
  - last_addr=0 writes exactly one byte.
  - last_addr=all-ones writes 2**ADDR_W bytes.
  - cur_addr never wraps, because the load terminates at last_addr.
- start outside IDLE is ignored. Changes to last_addr after it is sampled are ignored.

Decomposition:
- Shared package sap_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the loader state enum (IDLE, WAIT, ADDR, DATA, DONE).
- One natural sub-module, loader_addr_ctr: ADDR_W counter with sync clear, load-zero, increment and an at_last compare. The FSM stays in program_loader.

Test Plan:
- Load 3 bytes:
  - Stimulus: clear, then start with last_addr=2; send 0x1E, 0x2F, 0xE0 with byte_valid held high.
  - Expected: the load_addr_reg/bus pairs are 0x00, 0x01, 0x02; ram_write carries 0x1E, 0x2F, 0xE0; done pulses once 1 cycle after the last write; cpu_halt drops with IDLE.
- Backpressure:
  - Stimulus: byte_valid asserted during ADDR and DATA.
  - Expected: byte_ready=0; no capture; the next byte is taken only in WAIT. Each write's data equals the byte accepted for it.
- Full depth:
  - Stimulus: last_addr=0xF, 16 bytes 0x00..0x0F.
  - Expected: 16 writes to addresses 0..15; cur_addr ends at 0xF; no wrap; exactly one done pulse.
- Single byte:
  - Stimulus: last_addr=0, byte 0xA5.
  - Expected: one load_addr_reg with bus 0x00; one ram_write with 0xA5; done 1 cycle later.
- Abort and clear:
  - Abort in WAIT after 1 byte: IDLE next cycle; no further strobes; a new start restarts at address 0.
  - clear asserted in the ADDR cycle: all outputs 0 the following cycle; no ram_write is issued.
- Start conflicts:
  - start+abort in IDLE: stays IDLE.
  - start pulse mid-load: ignored; the sequence is unaffected.
